// File: rtl/config_loader.sv
// config_loader: turns a bit-serial configuration stream into single-cycle tile config bus writes.
// Define CONFIG_PARITY_EN to add a trailing even-parity bit per frame and the parity_err output.
module config_loader #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 22,
  parameter logic [ADDR_W-1:0] END_ADDR = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              bit_ready,
  output logic              config_en,
  output logic [ADDR_W-1:0] config_addr,
  output logic [DATA_W-1:0] config_data,
  output logic              busy,
  output logic              done,
`ifdef CONFIG_PARITY_EN
  output logic              parity_err,
`endif
  output logic [7:0]        frame_count
);

  localparam int FL = ADDR_W + DATA_W;
`ifdef CONFIG_PARITY_EN
  localparam int FRAME_W = FL + 1;
`else
  localparam int FRAME_W = FL;
`endif
  localparam int CNT_W = $clog2(FRAME_W);

  typedef enum logic [1:0] {IDLE, SHIFT, ISSUE, DONE} state_t;

  state_t              state_q, state_d;
  logic [FRAME_W-1:0]  shift_q, shift_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                en_q, en_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [7:0]          fcnt_q, fcnt_d;
  logic                perr_q, perr_d;

  // Frame as it will look once the current bit is shifted in; the write is
  // decided from this so config_en lands in the ISSUE cycle itself.
  logic [FRAME_W-1:0]  frame_w;
  logic [ADDR_W-1:0]   frame_addr;
  logic [DATA_W-1:0]   frame_data;
  logic                frame_par_ok;
  logic                held_par_ok;
  logic                held_is_end;
  logic                last_bit;

  assign frame_w    = {shift_q[FRAME_W-2:0], bit_in};
  assign frame_addr = frame_w[FRAME_W-1 -: ADDR_W];
  assign frame_data = frame_w[FRAME_W-1-ADDR_W -: DATA_W];
  assign last_bit   = (cnt_q == CNT_W'(FRAME_W - 1));
  assign held_is_end = (shift_q[FRAME_W-1 -: ADDR_W] == END_ADDR);

`ifdef CONFIG_PARITY_EN
  assign frame_par_ok = ~(^frame_w);
  assign held_par_ok  = ~(^shift_q);
`else
  assign frame_par_ok = 1'b1;
  assign held_par_ok  = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    en_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    fcnt_d  = fcnt_q;
    perr_d  = perr_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SHIFT;
          shift_d = '0;
          cnt_d   = '0;
          fcnt_d  = 8'd0;
          perr_d  = 1'b0;
        end
      end
      SHIFT: begin
        if (bit_valid) begin
          shift_d = frame_w;
          if (last_bit) begin
            cnt_d   = '0;
            state_d = ISSUE;
            if (!frame_par_ok) begin
              perr_d = 1'b1;
            end else if (frame_addr != END_ADDR) begin
              en_d   = 1'b1;
              addr_d = frame_addr;
              data_d = frame_data;
              fcnt_d = (fcnt_q == 8'hFF) ? fcnt_q : fcnt_q + 8'd1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ISSUE: begin
        // A corrupted end marker does not terminate the load.
        state_d = (held_is_end && held_par_ok) ? DONE : SHIFT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      fcnt_q  <= 8'd0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      fcnt_q  <= fcnt_d;
      perr_q  <= perr_d;
    end
  end

  assign bit_ready   = (state_q == SHIFT);
  assign busy        = (state_q == SHIFT) || (state_q == ISSUE);
  assign done        = (state_q == DONE);
  assign config_en   = en_q;
  assign config_addr = addr_q;
  assign config_data = data_q;
  assign frame_count = fcnt_q;
`ifdef CONFIG_PARITY_EN
  assign parity_err  = perr_q;
`else
  logic unused_perr;
  assign unused_perr = perr_q;
`endif

endmodule

// File: tb/tb_config_loader.sv
// Self-checking bench for config_loader: directed sequences, a vector table and a randomized load
// compared against a frame-level reference model.
module tb_config_loader;

`ifdef CONFIG_PARITY_EN
  localparam int FLT = 31;
`else
  localparam int FLT = 30;
`endif

  logic        clk = 1'b0;
  logic        rst, start, bit_in, bit_valid;
  logic        bit_ready, config_en, busy, done;
  logic [7:0]  config_addr, frame_count;
  logic [21:0] config_data;
`ifdef CONFIG_PARITY_EN
  logic        parity_err;
  bit          par_flip = 1'b0;
`endif

  config_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .config_en  (config_en),
    .config_addr(config_addr),
    .config_data(config_data),
    .busy       (busy),
    .done       (done),
`ifdef CONFIG_PARITY_EN
    .parity_err (parity_err),
`endif
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] a; logic [21:0] d; int cyc; } wr_t;
  wr_t wq[$];
  wr_t mq[$];

  // Every config_en cycle observed on the bus becomes one recorded write.
  always @(negedge clk) begin
    if (config_en) wq.push_back('{a: config_addr, d: config_data, cyc: cyc});
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end else begin
      $display("[TB] ok   %s = %0h", nm, got);
    end
  endtask

  // Streams nsend bits of a frame; stall inserts an invalid cycle before every bit.
  task automatic send_frame(input logic [7:0] a, input logic [21:0] d, input bit stall,
                            input int nsend, input bit mid_start, output int last_cyc);
    logic [FLT-1:0] f;
    int guard;
`ifdef CONFIG_PARITY_EN
    f = {a, d, (^{a, d}) ^ par_flip};
`else
    f = {a, d};
`endif
    last_cyc = 0;
    for (int i = 0; i < nsend; i++) begin
      if (stall) begin
        @(negedge clk);
        bit_valid = 1'b0;
        bit_in    = 1'($urandom);
        start     = 1'b0;
      end
      @(negedge clk);
      bit_in    = f[FLT-1-i];
      bit_valid = 1'b1;
      start     = mid_start && (i == 10);
      guard = 0;
      while (!bit_ready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 50) chk("bit_ready_timeout", 64'(guard), 64'd0);
      last_cyc = cyc;
    end
    @(negedge clk);
    bit_valid = 1'b0;
    start     = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic expect_write(input string nm, input logic [7:0] a, input logic [21:0] d,
                              input int lc, input bit chk_lat);
    wr_t w;
    settle();
    chk({nm, "_nwrites"}, 64'(wq.size()), 64'd1);
    if (wq.size() > 0) begin
      w = wq.pop_front();
      chk({nm, "_addr"}, 64'(w.a), 64'(a));
      chk({nm, "_data"}, 64'(w.d), 64'(d));
      if (chk_lat) chk({nm, "_latency"}, 64'(w.cyc), 64'(lc + 1));
    end
    wq.delete();
  endtask

  task automatic expect_none(input string nm);
    settle();
    chk({nm, "_nwrites"}, 64'(wq.size()), 64'd0);
    wq.delete();
  endtask

  typedef struct {
    logic [7:0]  addr;
    logic [21:0] data;
    bit          stall;
    bit          exp_en;
    logic [7:0]  exp_count;
    bit          exp_done;
  } vec_t;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    int lc;
    logic [7:0]  ra, last_a;
    logic [21:0] rd, last_d;
    int exp_n;
    bit st;

    tbl[0] = '{8'h10, 22'h000001, 1'b0, 1'b1, 8'd1, 1'b0};
    tbl[1] = '{8'h20, 22'h3FFFFF, 1'b1, 1'b1, 8'd2, 1'b0};
    tbl[2] = '{8'hFE, 22'h155555, 1'b0, 1'b1, 8'd3, 1'b0};
    tbl[3] = '{8'h00, 22'h000000, 1'b1, 1'b1, 8'd4, 1'b0};
    tbl[4] = '{8'h7F, 22'h200000, 1'b0, 1'b1, 8'd5, 1'b0};
    tbl[5] = '{8'hFF, 22'h123456, 1'b0, 1'b0, 8'd5, 1'b1};

    rst = 1'b1; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset then idle
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("reset_idle", {bit_ready, config_en, config_addr, config_data, busy, done, frame_count}, 64'd0);
    end

    // Single write and latency
    pulse_start();
    chk("busy_after_start", 64'(busy), 64'd1);
    send_frame(8'h03, 22'h2AB5C7, 1'b0, FLT, 1'b0, lc);
    expect_write("single", 8'h03, 22'h2AB5C7, lc, 1'b1);
    chk("single_count", 64'(frame_count), 64'd1);

    // Stall tolerance
    send_frame(8'h03, 22'h2AB5C7, 1'b1, FLT, 1'b0, lc);
    expect_write("stall", 8'h03, 22'h2AB5C7, lc, 1'b1);
    chk("stall_count", 64'(frame_count), 64'd2);
    send_frame(8'hFF, 22'h0, 1'b0, FLT, 1'b0, lc);
    expect_none("end1");
    chk("end1_done", 64'(done), 64'd1);

    // Multi-frame and end
    pulse_start();
    chk("restart_clears_done", 64'(done), 64'd0);
    for (int i = 0; i < 3; i++) begin
      send_frame(8'(i), 22'(i * 22'h11111), 1'b0, FLT, 1'b0, lc);
      expect_write("multi", 8'(i), 22'(i * 22'h11111), lc, 1'b1);
    end
    send_frame(8'hFF, 22'h3C3C3C, 1'b0, FLT, 1'b0, lc);
    expect_none("multi_end");
    chk("multi_status", {done, busy, frame_count}, {1'b1, 1'b0, 8'd3});
    chk("multi_addr_hold", {config_addr, config_data}, {8'h02, 22'(2 * 22'h11111)});

    // Abort mid-frame, then restart with an ignored mid-frame start
    pulse_start();
    send_frame(8'hA5, 22'h155AA5, 1'b0, 17, 1'b0, lc);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expect_none("abort");
    chk("abort_state", {busy, done, frame_count, config_en}, 64'd0);
    pulse_start();
    send_frame(8'h05, 22'h0ABCDE, 1'b0, FLT, 1'b1, lc);
    expect_write("restart", 8'h05, 22'h0ABCDE, lc, 1'b1);
    chk("restart_count", 64'(frame_count), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Vector table
    pulse_start();
    last_a = 8'h0; last_d = 22'h0;
    for (int i = 0; i < 6; i++) begin
      send_frame(tbl[i].addr, tbl[i].data, tbl[i].stall, FLT, 1'b0, lc);
      if (tbl[i].exp_en) begin
        expect_write($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].data, lc, 1'b1);
        last_a = tbl[i].addr;
        last_d = tbl[i].data;
      end else begin
        expect_none($sformatf("tbl%0d", i));
      end
      chk($sformatf("tbl%0d_count", i), 64'(frame_count), 64'(tbl[i].exp_count));
      chk($sformatf("tbl%0d_done", i), 64'(done), 64'(tbl[i].exp_done));
      chk($sformatf("tbl%0d_hold", i), {config_addr, config_data}, {last_a, last_d});
    end

    // Randomized back-to-back load against the frame-level model
    pulse_start();
    mq.delete();
    wq.delete();
    exp_n = 0;
    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom_range(0, 254));
      rd = 22'($urandom);
      st = 1'($urandom_range(0, 1));
      send_frame(ra, rd, st, FLT, 1'b0, lc);
      mq.push_back('{a: ra, d: rd, cyc: 0});
      exp_n = (exp_n < 255) ? exp_n + 1 : 255;
    end
    send_frame(8'hFF, 22'($urandom), 1'b0, FLT, 1'b0, lc);
    settle();
    chk("rand_nwrites", 64'(wq.size()), 64'(mq.size()));
    while (wq.size() > 0 && mq.size() > 0) begin
      wr_t g, e;
      g = wq.pop_front();
      e = mq.pop_front();
      chk("rand_write", {g.a, g.d}, {e.a, e.d});
    end
    wq.delete();
    chk("rand_status", {done, busy, frame_count}, {1'b1, 1'b0, 8'(exp_n)});

`ifdef CONFIG_PARITY_EN
    // Parity errors suppress the write and stick until the next start
    pulse_start();
    par_flip = 1'b1;
    send_frame(8'h04, 22'h012345, 1'b0, FLT, 1'b0, lc);
    expect_none("par_bad");
    chk("par_bad_err", {parity_err, frame_count}, {1'b1, 8'd0});
    par_flip = 1'b0;
    send_frame(8'h07, 22'h0FEDCB, 1'b0, FLT, 1'b0, lc);
    expect_write("par_good", 8'h07, 22'h0FEDCB, lc, 1'b1);
    chk("par_good_err", {parity_err, frame_count}, {1'b1, 8'd1});
    par_flip = 1'b1;
    send_frame(8'hFF, 22'h0, 1'b0, FLT, 1'b0, lc);
    expect_none("par_bad_end");
    chk("par_bad_end_state", {done, busy}, {1'b0, 1'b1});
    par_flip = 1'b0;
    send_frame(8'hFF, 22'h0, 1'b0, FLT, 1'b0, lc);
    settle();
    chk("par_end_done", {done, frame_count}, {1'b1, 8'd1});
    pulse_start();
    chk("par_clear_on_start", 64'(parity_err), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
